// File: rtl/mem_stage_pkg.sv
// Shared widths, state encoding and defaults for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned MEM_ADDR_BUS      = 32;
  localparam int unsigned REG_BUS           = 32;
  localparam int unsigned WORD_WIDTH        = 32;
  localparam int unsigned REG_ADDR_BUS      = 5;
  localparam int unsigned MEM_MAX_WAIT_DEF  = 15;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus: the MEM stage is the master, the memory the slave.
interface mem_stage_if import mem_stage_pkg::*; #(
  parameter int unsigned ADDR_W = MEM_ADDR_BUS,
  parameter int unsigned DATA_W = REG_BUS
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_wait_timer.sv
// Wait counter for an outstanding access; expire is high on the last allowed cycle.
module mem_wait_timer import mem_stage_pkg::*; #(
  parameter int unsigned MAX_WAIT = MEM_MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-memory accesses over a req/ack bus, stalls upstream
// while an access is outstanding and registers the MEM/WB values.
module mem_stage import mem_stage_pkg::*; #(
  parameter int unsigned ADDR_W     = MEM_ADDR_BUS,
  parameter int unsigned DATA_W     = REG_BUS,
  parameter int unsigned REG_ADDR_W = REG_ADDR_BUS,
  parameter int unsigned MAX_WAIT   = MEM_MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_mem_re,
  input  logic                  mem_mem_we,
  input  logic [ADDR_W-1:0]     mem_mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  mem_regfile_we,
  input  logic [REG_ADDR_W-1:0] mem_regfile_waddr,
  mem_stage_if.master           dbus,
  output logic                  stall_o,
  output logic                  mem_err,
  output logic                  wb_regfile_we,
  output logic [REG_ADDR_W-1:0] wb_regfile_waddr,
  output logic [DATA_W-1:0]     wb_data
);

  mem_state_e            state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  lat_rf_we_q, lat_rf_we_d;
  logic [REG_ADDR_W-1:0] lat_waddr_q, lat_waddr_d;
  logic                  err_q, err_d;
  logic                  wb_we_q, wb_we_d;
  logic [REG_ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  tmr_clr, tmr_en, tmr_expire;
  logic                  mem_op, illegal;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  assign mem_op  = mem_mem_re ^ mem_mem_we;
  assign illegal = mem_mem_re & mem_mem_we;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_rf_we_d = lat_rf_we_q;
    lat_waddr_d = lat_waddr_q;
    err_d       = 1'b0;
    wb_we_d     = 1'b0;
    wb_waddr_d  = wb_waddr_q;
    wb_data_d   = wb_data_q;
    stall_o     = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        tmr_clr = 1'b1;
        if (illegal) begin
          err_d = 1'b1;
        end else if (mem_op) begin
          stall_o     = 1'b1;
          req_d       = 1'b1;
          we_d        = mem_mem_we;
          addr_d      = mem_mem_addr;
          wdata_d     = mem_data;
          lat_rf_we_d = mem_regfile_we;
          lat_waddr_d = mem_regfile_waddr;
          state_d     = MEM_BUSY;
        end else begin
          wb_we_d    = mem_regfile_we;
          wb_waddr_d = mem_regfile_waddr;
          wb_data_d  = mem_data;
        end
      end
      MEM_BUSY: begin
        stall_o = ~dbus.dmem_ack;
        // Ack is tested before expiry so a last-cycle ack completes normally.
        if (dbus.dmem_ack) begin
          req_d      = 1'b0;
          state_d    = MEM_IDLE;
          wb_waddr_d = lat_waddr_q;
          if (!we_q) begin
            wb_we_d   = lat_rf_we_q;
            wb_data_d = dbus.dmem_rdata;
          end
        end else if (tmr_expire) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = MEM_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MEM_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_rf_we_q <= 1'b0;
      lat_waddr_q <= '0;
      err_q       <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_waddr_q  <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_rf_we_q <= lat_rf_we_d;
      lat_waddr_q <= lat_waddr_d;
      err_q       <= err_d;
      wb_we_q     <= wb_we_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign dbus.dmem_req   = req_q;
  assign dbus.dmem_we    = we_q;
  assign dbus.dmem_addr  = addr_q;
  assign dbus.dmem_wdata = wdata_q;
  assign mem_err          = err_q;
  assign wb_regfile_we    = wb_we_q;
  assign wb_regfile_waddr = wb_waddr_q;
  assign wb_data          = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases, a mid-access reset and
// randomized instruction streams against a transaction-level memory model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned MW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_mem_re, mem_mem_we;
  logic [AW-1:0] mem_mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_regfile_we;
  logic [RW-1:0] mem_regfile_waddr;
  logic          stall_o, mem_err, wb_regfile_we;
  logic [RW-1:0] wb_regfile_waddr;
  logic [DW-1:0] wb_data;

  mem_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_stage #(.ADDR_W(AW), .DATA_W(DW), .REG_ADDR_W(RW), .MAX_WAIT(MW)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_mem_re        (mem_mem_re),
    .mem_mem_we        (mem_mem_we),
    .mem_mem_addr      (mem_mem_addr),
    .mem_data          (mem_data),
    .mem_regfile_we    (mem_regfile_we),
    .mem_regfile_waddr (mem_regfile_waddr),
    .dbus              (bus.master),
    .stall_o           (stall_o),
    .mem_err           (mem_err),
    .wb_regfile_we     (wb_regfile_we),
    .wb_regfile_waddr  (wb_regfile_waddr),
    .wb_data           (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [RW-1:0] waddr;
    logic [DW-1:0] data;
  } ev_t;

  typedef struct {
    bit            re;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            rf_we;
    logic [RW-1:0] waddr;
    int unsigned   lat;   // req cycle in which the memory acks; > MW means never
  } op_t;

  ev_t           exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] dmem_arr[64];
  logic [DW-1:0] ref_mem[64];

  bit            cur_is_mem = 1'b0;
  bit            cur_we = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  int unsigned   plan_lat = 0;
  bit            resp_auto = 1'b1;
  logic          manual_ack = 1'b0;
  logic [DW-1:0] manual_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned widx(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a;
    return int'(t[7:2]);
  endfunction

  // Reference model: one instruction at a time, expressed as resulting events.
  task automatic issue(input op_t op);
    int unsigned n;
    int unsigned cnt;
    bit          timeout;
    ev_t         ev;
    n = 0;
    timeout = 1'b0;
    @(posedge clk); #1;
    mem_mem_re        = op.re;
    mem_mem_we        = op.we;
    mem_mem_addr      = op.addr;
    mem_data          = op.data;
    mem_regfile_we    = op.rf_we;
    mem_regfile_waddr = op.waddr;
    cur_is_mem = op.re ^ op.we;
    cur_we     = op.we;
    cur_addr   = op.addr;
    cur_wdata  = op.data;
    plan_lat   = op.lat;
    if (op.re && op.we) begin
      ev = '{is_err: 1'b1, waddr: '0, data: '0};
      exp_q.push_back(ev);
    end else if (!op.re && !op.we) begin
      if (op.rf_we) begin
        ev = '{is_err: 1'b0, waddr: op.waddr, data: op.data};
        exp_q.push_back(ev);
      end
    end else if (op.lat > MW) begin
      ev = '{is_err: 1'b1, waddr: '0, data: '0};
      exp_q.push_back(ev);
      n = MW + 1;
      timeout = 1'b1;
    end else begin
      n = op.lat;
      if (op.re) begin
        if (op.rf_we) begin
          ev = '{is_err: 1'b0, waddr: op.waddr, data: ref_mem[widx(op.addr)]};
          exp_q.push_back(ev);
        end
      end else begin
        ref_mem[widx(op.addr)] = op.data;
      end
    end
    cnt = 0;
    while (cnt <= n) begin
      @(negedge clk);
      if (!stall_o) break;
      cnt++;
      if (timeout && cnt == n) break;
    end
    check("stall_len", 64'(cnt), 64'(n));
  endtask

  task automatic idle_cycles(input int unsigned n);
    @(posedge clk); #1;
    mem_mem_re = 1'b0; mem_mem_we = 1'b0; mem_regfile_we = 1'b0;
    cur_is_mem = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  function automatic op_t mk(input bit re, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input bit rf_we,
                             input logic [RW-1:0] waddr, input int unsigned lat);
    op_t o;
    o.re = re; o.we = we; o.addr = addr; o.data = data;
    o.rf_we = rf_we; o.waddr = waddr; o.lat = lat;
    return o;
  endfunction

  // Memory responder: acks in the planned req cycle and checks the request.
  initial begin
    int unsigned   idx;
    int unsigned   b_plan;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_we;
    bit            unstable;
    idx = 0; b_plan = 0; b_addr = '0; b_wdata = '0; b_we = 1'b0; unstable = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!resp_auto) begin
        bus.dmem_ack = manual_ack;
        bus.dmem_rdata = manual_rdata;
        idx = 0;
        continue;
      end
      if (bus.dmem_req === 1'b1) begin
        if (idx == 0) begin
          b_plan = plan_lat; b_addr = bus.dmem_addr;
          b_we = bus.dmem_we; b_wdata = bus.dmem_wdata; unstable = 1'b0;
          check("req_is_memop", 64'(cur_is_mem), 64'd1);
          check("req_addr", 64'(b_addr), 64'(cur_addr));
          check("req_we", 64'(b_we), 64'(cur_we));
          check("req_wdata", 64'(b_wdata), 64'(cur_wdata));
        end else if (bus.dmem_addr !== b_addr || bus.dmem_we !== b_we ||
                     bus.dmem_wdata !== b_wdata) begin
          unstable = 1'b1;
        end
        idx++;
        if (idx == b_plan) begin
          bus.dmem_ack = 1'b1;
          if (b_we) dmem_arr[widx(b_addr)] = b_wdata;
          else      bus.dmem_rdata = dmem_arr[widx(b_addr)];
        end else begin
          bus.dmem_ack = 1'b0;
          bus.dmem_rdata = $urandom;
        end
      end else begin
        if (idx != 0) begin
          check("req_len", 64'(idx), 64'((b_plan < MW) ? b_plan : MW));
          check("req_stable", 64'(unstable), 64'd0);
          idx = 0;
        end
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = $urandom;
      end
    end
  end

  // Monitor: every writeback or error pulse must match the next expected event.
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && (wb_regfile_we === 1'b1 || mem_err === 1'b1)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {62'd0, mem_err, wb_regfile_we}, 64'd0);
        end else begin
          ev = exp_q.pop_front();
          if (ev.is_err) begin
            check("err_pulse", {62'd0, mem_err, wb_regfile_we}, 64'd2);
          end else begin
            check("wb_flags", {62'd0, mem_err, wb_regfile_we}, 64'd1);
            check("wb_waddr", 64'(wb_regfile_waddr), 64'(ev.waddr));
            check("wb_data", 64'(wb_data), 64'(ev.data));
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {55'd0, bus.dmem_req, bus.dmem_we, mem_err, wb_regfile_we,
                          wb_regfile_waddr}, 64'd0);
    check({tag, "_addr"}, 64'(bus.dmem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(bus.dmem_wdata), 64'd0);
    check({tag, "_wbdata"}, 64'(wb_data), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] v;
    op_t           o;
    int unsigned   k;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      dmem_arr[i] = v;
      ref_mem[i] = v;
    end
    dmem_arr[16] = 32'hDEAD_BEEF;
    ref_mem[16]  = 32'hDEAD_BEEF;

    rst = 1'b1;
    mem_mem_re = 1'b0; mem_mem_we = 1'b0; mem_mem_addr = '0; mem_data = '0;
    mem_regfile_we = 1'b0; mem_regfile_waddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_stall", 64'(stall_o), 64'd0);
    rst = 1'b0;

    issue(mk(0, 0, 32'h0,  32'h1234,      1, 5'd5, 0));
    issue(mk(1, 0, 32'h40, 32'h0,         1, 5'd3, 1));
    issue(mk(0, 1, 32'h80, 32'hA5A5A5A5,  1, 5'd9, 3));
    issue(mk(1, 0, 32'h80, 32'h0,         1, 5'd4, 1));
    issue(mk(1, 0, 32'h24, 32'h0,         1, 5'd6, MW + 1));
    issue(mk(0, 0, 32'h0,  32'hCAFE,      1, 5'd7, 0));
    issue(mk(1, 1, 32'h30, 32'h55,        1, 5'd8, 1));
    issue(mk(1, 0, 32'h10, 32'h0,         1, 5'd10, 2));
    issue(mk(1, 0, 32'h14, 32'h0,         1, 5'd11, 2));
    issue(mk(1, 0, 32'h18, 32'h0,         1, 5'd12, MW));
    idle_cycles(3);

    // Reset in the second BUSY cycle, then a stray ack while IDLE.
    @(posedge clk); #1;
    resp_auto = 1'b0; manual_ack = 1'b0;
    mem_mem_re = 1'b1; mem_mem_addr = 32'h20; mem_regfile_we = 1'b1; mem_regfile_waddr = 5'd7;
    @(posedge clk); #1;
    check("rst_test_req", 64'(bus.dmem_req), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_mem_re = 1'b0; mem_regfile_we = 1'b0;
    check_all_zero("midreset");
    manual_ack = 1'b1; manual_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    manual_ack = 1'b0;
    check("late_ack_wb", {62'd0, bus.dmem_req, wb_regfile_we}, 64'd0);
    @(posedge clk); #1;
    check("late_ack_stall", 64'(stall_o), 64'd0);
    resp_auto = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      o.addr  = AW'({$urandom_range(0, 63), 2'b00});
      o.data  = $urandom;
      o.rf_we = 1'($urandom_range(0, 1));
      o.waddr = RW'($urandom_range(0, 31));
      o.lat   = $urandom_range(1, MW + 1);
      o.re = (k >= 4 && k <= 6) || k == 9;
      o.we = (k >= 7);
      issue(o);
    end
    idle_cycles(5);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
